ac_exec_unit: RTL and testbench

AC_EXEC_UNIT -- requirements
Module: ac_exec_unit

---
 rtl/ac_exec_pkg.sv | 30 +++
 rtl/ac_exec_if.sv | 42 ++++
 rtl/ac_exec_wb.sv | 62 ++++++
 rtl/ac_exec_unit.sv | 89 ++++++++
 tb/tb_ac_exec_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ac_exec_pkg.sv
// Shared opcode, state and flag definitions for the AC execution unit.
// Imported by the interface, the writeback logic and the top.
package ac_exec_pkg;

  localparam int ALU_WAIT_MIN = 1;
  localparam int ALU_WAIT_MAX = 4;

  localparam int FLG_C = 3;
  localparam int FLG_V = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_ADD = 3'b001,
    OP_LDA = 3'b010,
    OP_CMA = 3'b011,
    OP_SHR = 3'b100,
    OP_SHL = 3'b101,
    OP_NOP = 3'b110,
    OP_CLR = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/ac_exec_if.sv
// Command, response and ALU-side signals of the AC execution unit.
// The unit uses the slave modport; the environment uses master.
interface ac_exec_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_dr;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_ac;
  logic        rsp_e;
  logic [3:0]  rsp_flags;

  logic [2:0]  alu_aselect;
  logic [15:0] alu_ac;
  logic [15:0] alu_dr;
  logic        alu_e;
  logic [16:0] alu_out;
  logic        alu_co;
  logic        alu_ovf;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dr,
    output cmd_ready,
    output rsp_valid, rsp_ac, rsp_e, rsp_flags,
    input  rsp_ready,
    output alu_aselect, alu_ac, alu_dr, alu_e,
    input  alu_out, alu_co, alu_ovf
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dr,
    input  cmd_ready,
    input  rsp_valid, rsp_ac, rsp_e, rsp_flags,
    output rsp_ready,
    input  alu_aselect, alu_ac, alu_dr, alu_e,
    output alu_out, alu_co, alu_ovf
  );

endinterface

// File: rtl/ac_exec_wb.sv
// Next AC/E/flags from the ALU result; Z is derived here,
// never taken from the ALU.
module ac_exec_wb
  import ac_exec_pkg::*;
(
  input  op_e         op_i,
  input  logic [16:0] alu_out_i,
  input  logic        alu_ovf_i,
  input  logic [15:0] ac_i,
  input  logic        e_i,
  input  logic [3:0]  flags_i,
  output logic [15:0] ac_o,
  output logic        e_o,
  output logic [3:0]  flags_o
);

  logic [15:0] res;
  logic        n_f;
  logic        z_f;

  assign res = alu_out_i[15:0];
  assign n_f = res[15];
  assign z_f = (res == 16'h0000);

  always_comb begin
    ac_o    = ac_i;
    e_o     = e_i;
    flags_o = flags_i;
    unique case (op_i)
      OP_AND, OP_LDA, OP_CMA: begin
        ac_o           = res;
        flags_o        = '0;
        flags_o[FLG_N] = n_f;
        flags_o[FLG_Z] = z_f;
      end
      OP_ADD: begin
        ac_o           = res;
        e_o            = alu_out_i[16];
        flags_o[FLG_C] = alu_out_i[16];
        flags_o[FLG_V] = alu_ovf_i;
        flags_o[FLG_N] = n_f;
        flags_o[FLG_Z] = z_f;
      end
      OP_SHR, OP_SHL: begin
        ac_o           = res;
        e_o            = alu_out_i[16];
        flags_o[FLG_C] = alu_out_i[16];
        flags_o[FLG_V] = 1'b0;
        flags_o[FLG_N] = n_f;
        flags_o[FLG_Z] = z_f;
      end
      OP_CLR: begin
        ac_o           = '0;
        e_o            = 1'b0;
        flags_o        = '0;
        flags_o[FLG_Z] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ac_exec_unit.sv
// AC/E execution unit: accepts one command, drives the ALU for
// ALU_WAIT cycles, writes back, then holds the response.
module ac_exec_unit
  import ac_exec_pkg::*;
#(
  parameter int ALU_WAIT = 1
) (
  input  logic      clk,
  input  logic      reset,
  ac_exec_if.slave  bus
);

  localparam logic [1:0] LAST = 2'(ALU_WAIT - 1);

  state_e      state_q;
  op_e         op_q;
  logic [15:0] dr_q;
  logic [1:0]  cnt_q;
  logic [15:0] ac_q;
  logic        e_q;
  logic [3:0]  flags_q;

  logic [15:0] ac_d;
  logic        e_d;
  logic [3:0]  flags_d;

  ac_exec_wb u_wb (
    .op_i      (op_q),
    .alu_out_i (bus.alu_out),
    .alu_ovf_i (bus.alu_ovf),
    .ac_i      (ac_q),
    .e_i       (e_q),
    .flags_i   (flags_q),
    .ac_o      (ac_d),
    .e_o       (e_d),
    .flags_o   (flags_d)
  );

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_ac    = ac_q;
  assign bus.rsp_e     = e_q;
  assign bus.rsp_flags = flags_q;

  // ALU sees NOP unless a command is actually in flight
  assign bus.alu_aselect =
    (state_q == S_ISSUE) ? op_q : OP_NOP;
  assign bus.alu_ac = ac_q;
  assign bus.alu_dr = dr_q;
  assign bus.alu_e  = e_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      dr_q    <= '0;
      cnt_q   <= '0;
      ac_q    <= '0;
      e_q     <= 1'b0;
      flags_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q    <= op_e'(bus.cmd_op);
            dr_q    <= bus.cmd_dr;
            cnt_q   <= '0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cnt_q == LAST) begin
            ac_q    <= ac_d;
            e_q     <= e_d;
            flags_q <= flags_d;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac_exec_unit.sv
// Directed bench for ac_exec_unit at ALU_WAIT=1 and ALU_WAIT=4,
// with a behavioural team ALU on the alu_* side.
module tb_ac_exec_unit;

  logic clk = 1'b0;
  logic rst;
  int   sel;
  int   w;
  int   ntest;
  int   nfail;

  logic        cv;
  logic [2:0]  cop;
  logic [15:0] cdr;
  logic        rr;

  ac_exec_if if1 ();
  ac_exec_if if4 ();

  always #5 clk = ~clk;

  ac_exec_unit #(.ALU_WAIT(1)) dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (if1.slave)
  );

  ac_exec_unit #(.ALU_WAIT(4)) dut4 (
    .clk   (clk),
    .reset (rst),
    .bus   (if4.slave)
  );

  function automatic logic [17:0] alu_f(
    input logic [2:0]  s,
    input logic [15:0] a,
    input logic [15:0] d,
    input logic        e
  );
    logic [16:0] r;
    logic        v;
    r = {e, a};
    v = 1'b0;
    case (s)
      3'b000: r = {e, a & d};
      3'b001: begin
        r = {1'b0, a} + {1'b0, d};
        v = (a[15] == d[15]) && (r[15] != a[15]);
      end
      3'b010: r = {e, d};
      3'b011: r = {e, ~a};
      3'b100: r = {a[0], e, a[15:1]};
      3'b101: r = {a[15], a[14:0], e};
      default: r = {e, a};
    endcase
    return {v, r};
  endfunction

  assign {if1.alu_ovf, if1.alu_out} =
    alu_f(if1.alu_aselect, if1.alu_ac, if1.alu_dr, if1.alu_e);
  assign if1.alu_co = if1.alu_out[16];
  assign {if4.alu_ovf, if4.alu_out} =
    alu_f(if4.alu_aselect, if4.alu_ac, if4.alu_dr, if4.alu_e);
  assign if4.alu_co = if4.alu_out[16];

  assign if1.cmd_valid = cv && (sel == 0);
  assign if4.cmd_valid = cv && (sel == 1);
  assign if1.cmd_op    = cop;
  assign if4.cmd_op    = cop;
  assign if1.cmd_dr    = cdr;
  assign if4.cmd_dr    = cdr;
  assign if1.rsp_ready = rr && (sel == 0);
  assign if4.rsp_ready = rr && (sel == 1);

  logic        o_crdy;
  logic        o_rv;
  logic [15:0] o_ac;
  logic        o_e;
  logic [3:0]  o_fl;
  logic [2:0]  o_as;

  assign o_crdy = sel ? if4.cmd_ready   : if1.cmd_ready;
  assign o_rv   = sel ? if4.rsp_valid   : if1.rsp_valid;
  assign o_ac   = sel ? if4.rsp_ac      : if1.rsp_ac;
  assign o_e    = sel ? if4.rsp_e       : if1.rsp_e;
  assign o_fl   = sel ? if4.rsp_flags   : if1.rsp_flags;
  assign o_as   = sel ? if4.alu_aselect : if1.alu_aselect;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s W=%0d observed=%h expected=%h",
             tag, w, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(
    input string       tag,
    input logic [2:0]  op,
    input logic [15:0] dr,
    input logic [15:0] eac,
    input logic        ee,
    input logic [3:0]  efl
  );
    int n;
    chk({tag, ".rdy"}, 32'(o_crdy), 32'd1);
    cv  = 1'b1;
    cop = op;
    cdr = dr;
    step();
    cv = 1'b0;
    chk({tag, ".asel"}, 32'(o_as), 32'(op));
    n = 0;
    while (!o_rv && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".lat"}, n, w);
    chk({tag, ".ac"}, 32'(o_ac), 32'(eac));
    chk({tag, ".e"}, 32'(o_e), 32'(ee));
    chk({tag, ".fl"}, 32'(o_fl), 32'(efl));
    rr = 1'b1;
    step();
    rr = 1'b0;
    chk({tag, ".idle"}, 32'(o_crdy), 32'd1);
  endtask

  initial begin
    ntest = 0;
    nfail = 0;
    cv    = 1'b0;
    cop   = 3'b110;
    cdr   = '0;
    rr    = 1'b0;
    rst   = 1'b1;
    sel   = 0;
    w     = 1;

    for (int s = 0; s < 2; s++) begin
      sel = s;
      w   = (s == 0) ? 1 : 4;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst.rdy", 32'(o_crdy), 32'd1);
      chk("rst.rv", 32'(o_rv), 32'd0);
      chk("rst.ac", 32'(o_ac), 32'h0);
      chk("rst.e", 32'(o_e), 32'd0);
      chk("rst.fl", 32'(o_fl), 32'h0);
      chk("rst.asel", 32'(o_as), 32'h6);

      do_cmd("lda7fff", 3'b010, 16'h7FFF, 16'h7FFF, 1'b0, 4'b0000);
      do_cmd("addovf", 3'b001, 16'h0001, 16'h8000, 1'b0, 4'b0110);
      do_cmd("ldaffff", 3'b010, 16'hFFFF, 16'hFFFF, 1'b0, 4'b0010);
      do_cmd("addwrap", 3'b001, 16'h0001, 16'h0000, 1'b1, 4'b1001);
      do_cmd("clr0", 3'b111, 16'h1234, 16'h0000, 1'b0, 4'b0001);
      do_cmd("lda8001", 3'b010, 16'h8001, 16'h8001, 1'b0, 4'b0010);
      do_cmd("shl", 3'b101, 16'h0000, 16'h0002, 1'b1, 4'b1000);
      do_cmd("lda0003", 3'b010, 16'h0003, 16'h0003, 1'b1, 4'b0000);
      do_cmd("shr", 3'b100, 16'h0000, 16'h8001, 1'b1, 4'b1010);
      do_cmd("clr1", 3'b111, 16'h0000, 16'h0000, 1'b0, 4'b0001);
      do_cmd("cma", 3'b011, 16'h0000, 16'hFFFF, 1'b0, 4'b0010);
      do_cmd("nop", 3'b110, 16'h5A5A, 16'hFFFF, 1'b0, 4'b0010);
      do_cmd("and", 3'b000, 16'h0F0F, 16'h0F0F, 1'b0, 4'b0000);
      do_cmd("and0", 3'b000, 16'h0000, 16'h0000, 1'b0, 4'b0001);

      do_cmd("lda1234", 3'b010, 16'h1234, 16'h1234, 1'b0, 4'b0000);
      rr = 1'b0;
      cv  = 1'b1;
      cop = 3'b010;
      cdr = 16'h5555;
      step();
      chk("bp.acc", 32'(o_crdy), 32'd0);
      begin
        int n;
        n = 0;
        while (!o_rv && n < 20) begin
          step();
          n++;
        end
        chk("bp.lat", n, w);
      end
      for (int k = 0; k < 5; k++) begin
        step();
        chk("bp.rv", 32'(o_rv), 32'd1);
        chk("bp.rdy", 32'(o_crdy), 32'd0);
        chk("bp.ac", 32'(o_ac), 32'h5555);
      end
      rr = 1'b1;
      step();
      rr = 1'b0;
      chk("bp.idle", 32'(o_crdy), 32'd1);
      chk("bp.rvlo", 32'(o_rv), 32'd0);
      step();
      cv = 1'b0;
      chk("bp.acc2", 32'(o_crdy), 32'd0);
      begin
        int n;
        n = 0;
        while (!o_rv && n < 20) begin
          step();
          n++;
        end
        chk("bp.lat2", n, w);
        chk("bp.ac2", 32'(o_ac), 32'h5555);
      end
      rr = 1'b1;
      step();
      rr = 1'b0;

      do_cmd("ldaffff2", 3'b010, 16'hFFFF, 16'hFFFF, 1'b0, 4'b0010);
      cv  = 1'b1;
      cop = 3'b001;
      cdr = 16'h0001;
      step();
      cv = 1'b0;
      chk("rs.iss", 32'(o_as), 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rs.ac", 32'(o_ac), 32'h0);
      chk("rs.e", 32'(o_e), 32'd0);
      chk("rs.fl", 32'(o_fl), 32'h0);
      chk("rs.rv", 32'(o_rv), 32'd0);
      chk("rs.rdy", 32'(o_crdy), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
